mem_port_arbiter: RTL

- Shares a single 32-bit memory read port between two requesters: A (instruction fetch) and B (data load).
- Arbitrates round-robin and drives the select of the 32-bit 2-to-1 address mux.
- Sequences a fixed-latency access, then returns the read word with a one-cycle acknowledge to the winner.
- Sits between the fetch/MEM stages and the shared memory model.

---
 rtl/mem_port_arbiter_pkg.sv | 29 ++
 rtl/Mux32Bit2To1.sv | 11 +
 rtl/mem_port_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the two-requester memory read-port arbiter.
package mem_port_arbiter_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   localparam logic GRANT_A = 1'b0;
   localparam logic GRANT_B = 1'b1;

   // Round-robin pick: a lone requester wins, a tie goes to whoever did not win last.
   function automatic logic rr_pick(input logic req_a, input logic req_b, input logic last_grant);
      logic grant;
      if (req_a && req_b) begin
         grant = ~last_grant;
      end else if (req_b) begin
         grant = GRANT_B;
      end else begin
         grant = GRANT_A;
      end
      return grant;
   endfunction

endpackage

// File: rtl/Mux32Bit2To1.sv
// 32-bit 2-to-1 mux: i_sel=0 passes i_in0, i_sel=1 passes i_in1.
module Mux32Bit2To1 (
   input  logic [31:0] i_in0,
   input  logic [31:0] i_in1,
   input  logic        i_sel,
   output logic [31:0] o_out
);

   assign o_out = i_sel ? i_in1 : i_in0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory read port between
// instruction fetch (A) and data load (B); returns the word with a one-cycle ack.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned LATENCY = 3,
   parameter int unsigned CNT_W   = 4
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              ReqA,
   input  logic [ADDR_W-1:0] AddrA,
   input  logic              ReqB,
   input  logic [ADDR_W-1:0] AddrB,
   input  logic [DATA_W-1:0] MemRdData,
   output logic              Sel,
   output logic [ADDR_W-1:0] MemAddr,
   output logic              MemEn,
   output logic              AckA,
   output logic              AckB,
   output logic [DATA_W-1:0] RdData,
   output logic              Busy
);

   state_t              r_state;
   logic                r_last_grant;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_sel;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic                r_mem_en;
   logic                r_ack_a;
   logic                r_ack_b;
   logic [DATA_W-1:0]   r_rd_data;
   logic                r_busy;

   logic                w_grant;
   logic [ADDR_W-1:0]   w_mux_addr;

   assign w_grant = rr_pick(ReqA, ReqB, r_last_grant);

   Mux32Bit2To1 u_addr_mux (
      .i_in0 (AddrA),
      .i_in1 (AddrB),
      .i_sel (w_grant),
      .o_out (w_mux_addr)
   );

   // Grant only in IDLE; Sel/MemAddr then stay frozen until the next grant.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state      <= ST_IDLE;
         r_last_grant <= GRANT_B;
         r_cnt        <= '0;
         r_sel        <= GRANT_A;
         r_mem_addr   <= '0;
         r_mem_en     <= 1'b0;
         r_ack_a      <= 1'b0;
         r_ack_b      <= 1'b0;
         r_rd_data    <= '0;
         r_busy       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_ack_a <= 1'b0;
               r_ack_b <= 1'b0;
               if (ReqA || ReqB) begin
                  r_state      <= ST_ACCESS;
                  r_sel        <= w_grant;
                  r_mem_addr   <= w_mux_addr;
                  r_last_grant <= w_grant;
                  r_cnt        <= CNT_W'(LATENCY - 1);
                  r_mem_en     <= 1'b1;
                  r_busy       <= 1'b1;
               end
            end
            ST_ACCESS: begin
               if (r_cnt == '0) begin
                  r_state   <= ST_RESP;
                  r_rd_data <= MemRdData;
                  r_mem_en  <= 1'b0;
                  r_ack_a   <= (r_sel == GRANT_A);
                  r_ack_b   <= (r_sel == GRANT_B);
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            ST_RESP: begin
               r_state <= ST_IDLE;
               r_ack_a <= 1'b0;
               r_ack_b <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state  <= ST_IDLE;
               r_mem_en <= 1'b0;
               r_ack_a  <= 1'b0;
               r_ack_b  <= 1'b0;
               r_busy   <= 1'b0;
            end
         endcase
      end
   end

   assign Sel     = r_sel;
   assign MemAddr = r_mem_addr;
   assign MemEn   = r_mem_en;
   assign AckA    = r_ack_a;
   assign AckB    = r_ack_b;
   assign RdData  = r_rd_data;
   assign Busy    = r_busy;

endmodule
